// File: rtl/dma_pkg.sv
// Shared types for the DMA command issuer: the queued request record,
// the issue FSM state encoding and the number of command beats per request.
package dma_pkg;

  // Address / length width the request record is laid out with.
  localparam int DMA_SZ = 8;

  // Every request reaches the device as this many bus beats.
  localparam int CMD_BEATS = 2;

  typedef struct packed {
    logic [DMA_SZ-1:0] dev_addr;
    logic [DMA_SZ-1:0] length;
    logic [DMA_SZ-1:0] mem_addr;
    logic              w_notr;
  } dma_req_t;

  typedef enum logic [2:0] {
    IDLE,
    ZERO,
    CMD0,
    CMD1,
    WAIT
  } dma_issue_state_t;

endpackage

// File: rtl/dma_req_fifo.sv
// Request FIFO for the DMA command issuer. Pointers carry one extra wrap bit
// so full and empty are told apart by the MSB compare; a push while full is
// dropped, and a push and a pop in the same cycle are both honoured.
module dma_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Advance the write/read pointers; reset empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dma_cmd_issuer.sv
// DMA command issuer: queues host requests, issues each as a two-beat command
// on the shared addr/data bus framed by rx_interrupt, then waits for the
// device's completion edge on tx_interrupt and reports done to the host.
// Optional feature: define DMA_TIMEOUT_EN to retire a request with
// done_err=1 after TIMEOUT_CYCLES cycles in WAIT without a completion edge.
// SZ must equal dma_pkg::DMA_SZ since the queued record layout lives there.
module dma_cmd_issuer
  import dma_pkg::*;
#(
  parameter int SZ             = DMA_SZ,
  parameter int WSZ            = 8,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [SZ-1:0] req_dev_addr,
  input  logic [SZ-1:0] req_length,
  input  logic [SZ-1:0] req_mem_addr,
  input  logic          req_w_notr,
  output logic          rx_interrupt,
  input  logic          tx_interrupt,
  inout  wire [SZ-1:0]  addr,
  inout  wire [WSZ-1:0] data,
  output logic          done,
  output logic          done_err,
  output logic          busy
);

  dma_req_t         req_in;
  dma_req_t         head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  dma_issue_state_t state;
  logic             tx_q;
  logic             tx_edge;
  logic             timeout_hit;
  logic [SZ-1:0]    addr_q;
  logic [WSZ-1:0]   data_q;
  logic [SZ-1:0]    mem_addr_w;
  logic             w_notr_w;

  assign req_in    = {req_dev_addr, req_length, req_mem_addr, req_w_notr};
  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && !fifo_full;
  // The done cycle of a retired request is kept separate from the next pop,
  // so the following CMD0 lands two cycles after done.
  assign fifo_pop  = (state == IDLE) && !done && !fifo_empty;
  assign tx_edge   = tx_interrupt && !tx_q;
  assign busy      = (state != IDLE) || !fifo_empty;

  // The bus is only ever driven during the two command beats.
  assign addr = rx_interrupt ? addr_q : 'z;
  assign data = rx_interrupt ? data_q : 'z;

  dma_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(dma_req_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (req_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Previous tx_interrupt level; it tracks in every state so a level held
  // high across requests never produces a second completion edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_q <= 1'b0;
    else      tx_q <= tx_interrupt;
  end

  // Issue FSM with registered outputs set on entry to each state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rx_interrupt <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      mem_addr_w   <= '0;
      w_notr_w     <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            if (head.length == '0) begin
              state <= ZERO;
              done  <= 1'b1;
            end else begin
              state        <= CMD0;
              rx_interrupt <= 1'b1;
              addr_q       <= head.dev_addr;
              data_q       <= WSZ'(head.length);
              mem_addr_w   <= head.mem_addr;
              w_notr_w     <= head.w_notr;
            end
          end
        end
        ZERO: begin
          state <= IDLE;
        end
        CMD0: begin
          state  <= CMD1;
          addr_q <= mem_addr_w;
          data_q <= {{(WSZ-1){1'b0}}, w_notr_w};
        end
        CMD1: begin
          state        <= WAIT;
          rx_interrupt <= 1'b0;
        end
        WAIT: begin
          if (tx_edge) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (timeout_hit) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          rx_interrupt <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMA_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign done_err    = err_q;

  // Cycles spent in WAIT; held at zero elsewhere so each WAIT entry starts fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                wait_cnt <= '0;
    else if (state != WAIT)  wait_cnt <= '0;
    else                     wait_cnt <= wait_cnt + 1'b1;
  end

  // Error flag rides with done only when the timeout, not an edge, retires the request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= timeout_hit && !tx_edge;
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign done_err           = 1'b0;
`endif

endmodule
